// File: rtl/astro_path_pkg.sv
// Shared constants, state encoding and node-range helper for the path
// planner, path streamer and path-mapping blocks.
package astro_path_pkg;

  localparam int NODE_W    = 5;
  localparam int NUM_NODES = 30;
  localparam int MAX_PATH  = 16;

  localparam logic [NODE_W-1:0] NODE_INVALID = 5'd31;
  localparam logic [NODE_W-1:0] NODE_LIMIT   = NODE_W'(NUM_NODES);
  // Old depth value at which the pushed node fills the stack.
  localparam logic [NODE_W-1:0] DEPTH_LIMIT  = NODE_W'(MAX_PATH - 1);

  typedef enum logic [2:0] {IDLE, TRACE, EMIT, FIN, ERR} path_state_t;

  function automatic logic node_valid(input logic [NODE_W-1:0] n);
    return n < NODE_LIMIT;
  endfunction

endpackage

// File: rtl/path_streamer_if.sv
// Planner-side bus of the path streamer: table writes, start request and
// the serial path-load stream.
interface path_streamer_if;

  // start is a one-cycle request honoured only while busy is low; there is
  // no ready back-pressure on the stream: path_input qualifies path_planned
  // for exactly one cycle per node and the consumer must take it.
  logic                               parent_we;
  logic [astro_path_pkg::NODE_W-1:0]  parent_addr;
  logic [astro_path_pkg::NODE_W-1:0]  parent_data;
  logic                               start;
  logic [astro_path_pkg::NODE_W-1:0]  start_node;
  logic [astro_path_pkg::NODE_W-1:0]  end_node;
  logic                               busy;
  logic                               path_input;
  logic [astro_path_pkg::NODE_W-1:0]  path_planned;
  logic [astro_path_pkg::NODE_W-1:0]  path_len;
  logic                               done;
  logic                               error;

  modport master (
    output parent_we, parent_addr, parent_data, start, start_node, end_node,
    input  busy, path_input, path_planned, path_len, done, error
  );

  modport slave (
    input  parent_we, parent_addr, parent_data, start, start_node, end_node,
    output busy, path_input, path_planned, path_len, done, error
  );

endinterface

// File: rtl/path_stack.sv
// LIFO holding the traced route end-first so it pops start-first.
module path_stack
  import astro_path_pkg::*;
#(
  parameter int DEPTH = MAX_PATH,
  parameter int W     = NODE_W,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] cnt;
  logic          can_push;

  assign can_push = push && !clear && (cnt != CW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (can_push) begin
      cnt <= cnt + CW'(1);
    end else if (pop && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Storage needs no reset: entries above the count are never observed.
  always_ff @(posedge clk) begin
    if (can_push) begin
      mem[AW'(cnt)] <= din;
    end
  end

  assign dout  = (cnt != '0) ? mem[AW'(cnt - CW'(1))] : '0;
  assign count = cnt;

endmodule

// File: rtl/path_streamer.sv
// Walks the predecessor table back from the end node into a LIFO, then
// streams the route start-first, one node per cycle.
module path_streamer
  import astro_path_pkg::*;
(
  input  logic            clk_3125KHz,
  input  logic            rst_n,
  path_streamer_if.slave  bus,
  output path_state_t     fsm_state
);

  localparam int CW = $clog2(MAX_PATH + 1);

  path_state_t       state, state_next;
  logic [NODE_W-1:0] parent_tbl [NUM_NODES];
  logic [NODE_W-1:0] cursor, start_q, depth, len_q, held, par, top;
  logic              push, pop, clear;
  logic [CW-1:0]     count;

  assign par = parent_tbl[cursor];

  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NODES; i++) parent_tbl[i] <= NODE_INVALID;
    end else if (state == IDLE && bus.parent_we && node_valid(bus.parent_addr)) begin
      parent_tbl[bus.parent_addr] <= bus.parent_data;
    end
  end

  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    push       = 1'b0;
    pop        = 1'b0;
    clear      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = (node_valid(bus.start_node) && node_valid(bus.end_node))
                       ? TRACE : ERR;
        end
      end
      TRACE: begin
        push = 1'b1;
        if (cursor == start_q)       state_next = EMIT;
        else if (!node_valid(par))   state_next = ERR;
        else if (depth == DEPTH_LIMIT) state_next = ERR;
      end
      EMIT: begin
        pop = 1'b1;
        if (count == CW'(1)) state_next = FIN;
      end
      FIN: state_next = IDLE;
      ERR: begin
        clear      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Cursor follows the parent link unconditionally in TRACE; the value is
  // dead once the trace leaves that state.
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= '0;
      cursor  <= '0;
      depth   <= '0;
      len_q   <= '0;
      held    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            start_q <= bus.start_node;
            cursor  <= bus.end_node;
            depth   <= '0;
          end
        end
        TRACE: begin
          depth  <= depth + NODE_W'(1);
          cursor <= par;
        end
        EMIT: begin
          held <= top;
          if (count == CW'(1)) len_q <= depth;
        end
        default: ;
      endcase
    end
  end

  path_stack u_stack (
    .clk   (clk_3125KHz),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .din   (cursor),
    .dout  (top),
    .count (count)
  );

  assign bus.busy         = (state != IDLE);
  assign bus.path_input   = (state == EMIT);
  assign bus.path_planned = (state == EMIT) ? top : held;
  assign bus.path_len     = len_q;
  assign bus.done         = (state == FIN);
  assign bus.error        = (state == ERR);
  assign fsm_state        = state;

endmodule

// File: tb/tb_path_streamer.sv
// Directed bench for path_streamer: route-level model with per-cycle compare
// plus literal checks of stream contents and event offsets.
`timescale 1ns/1ps
module tb_path_streamer;
  import astro_path_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk_3125KHz = 1'b0;
  logic rst_n       = 1'b0;
  always #160 clk_3125KHz = ~clk_3125KHz;

  path_streamer_if bus ();
  path_state_t     fsm_state;

  path_streamer dut (
    .clk_3125KHz (clk_3125KHz),
    .rst_n       (rst_n),
    .bus         (bus),
    .fsm_state   (fsm_state)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk_3125KHz) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  // ---------------- model ----------------
  // Record per expected cycle: {busy, path_input, done, error, node[4:0]}
  logic [8:0] exp_q[$];
  int         model_tbl [32];
  int         model_len   = 0;
  int         pending_len = 0;
  logic       model_busy_now = 1'b0;

  function automatic logic [8:0] mk(input bit b, input bit p, input bit d,
                                    input bit e, input int n);
    return {b, p, d, e, 5'(n)};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 32; i++) model_tbl[i] = 31;
    model_len      = 0;
    pending_len    = 0;
    model_busy_now = 1'b0;
  endtask

  // Route walk from the end node; k is the number of trace cycles spent.
  task automatic model_start(input int s, input int e);
    int  route[$];
    int  cur, k;
    bit  ok, stop;
    if (s >= NUM_NODES || e >= NUM_NODES) begin
      exp_q.push_back(mk(1, 0, 0, 1, 0));
      return;
    end
    cur = e; k = 0; ok = 0; stop = 0;
    while (!stop) begin
      k++;
      route.push_front(cur);
      if (cur == s) begin
        ok = 1; stop = 1;
      end else if (model_tbl[cur] >= NUM_NODES || k == MAX_PATH) begin
        stop = 1;
      end else begin
        cur = model_tbl[cur];
      end
    end
    repeat (k) exp_q.push_back(mk(1, 0, 0, 0, 0));
    if (ok) begin
      foreach (route[i]) exp_q.push_back(mk(1, 1, 0, 0, route[i]));
      exp_q.push_back(mk(1, 0, 1, 0, 0));
      pending_len = route.size();
    end else begin
      exp_q.push_back(mk(1, 0, 0, 1, 0));
    end
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk_3125KHz) begin
    logic [8:0] r;
    r = (exp_q.size() != 0) ? exp_q.pop_front() : 9'd0;
    model_busy_now = r[8];
    if (r[6]) model_len = pending_len;
    check("busy", int'(bus.busy), int'(r[8]));
    check("path_input", int'(bus.path_input), int'(r[7]));
    check("done", int'(bus.done), int'(r[6]));
    check("error", int'(bus.error), int'(r[5]));
    check("path_len", int'(bus.path_len), model_len);
    check("fsm_idle", int'(fsm_state == IDLE), int'(!r[8]));
    if (r[7]) check("path_planned", int'(bus.path_planned), int'(r[4:0]));
  end

  // ---------------- monitor ----------------
  int mon_nodes[$];
  int first_pin = -1, done_at = -1, err_at = -1, start_t = 0;

  always @(negedge clk_3125KHz) begin
    if (bus.path_input) begin
      if (mon_nodes.size() == 0) first_pin = cyc + 1;
      mon_nodes.push_back(int'(bus.path_planned));
    end
    if (bus.done)  done_at = cyc + 1;
    if (bus.error) err_at  = cyc + 1;
  end

  task automatic clear_mon();
    mon_nodes.delete();
    first_pin = -1; done_at = -1; err_at = -1;
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(negedge clk_3125KHz);
    #1;
  endtask

  task automatic write_parent(input int a, input int d);
    bus.parent_we   = 1'b1;
    bus.parent_addr = 5'(a);
    bus.parent_data = 5'(d);
    if (!model_busy_now && a < NUM_NODES) model_tbl[a] = d;
    tick();
    bus.parent_we = 1'b0;
  endtask

  task automatic start_path(input int s, input int e);
    bus.start      = 1'b1;
    bus.start_node = 5'(s);
    bus.end_node   = 5'(e);
    if (!model_busy_now) begin
      start_t = cyc + 1;
      model_start(s, e);
    end
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      tick();
      n++;
    end while ((exp_q.size() != 0 || model_busy_now) && n < 300);
    if (n >= 300) begin
      tests++; fails++;
      $display("FAIL wait_idle: model still busy after %0d cycles", n);
    end
    tick();
  endtask

  task automatic check_nominal(input string tag);
    int nom[6];
    nom = '{0, 1, 29, 20, 21, 22};
    check({tag, "_count"}, mon_nodes.size(), 6);
    for (int i = 0; i < 6 && i < mon_nodes.size(); i++)
      check({tag, "_node"}, mon_nodes[i], nom[i]);
    check({tag, "_first_ofs"}, first_pin - start_t, 7);
    check({tag, "_done_ofs"}, done_at - start_t, 13);
    check({tag, "_len"}, int'(bus.path_len), 6);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bus.parent_we = 1'b0; bus.parent_addr = '0; bus.parent_data = '0;
    bus.start = 1'b0; bus.start_node = '0; bus.end_node = '0;
    model_reset();
    repeat (3) tick();
    check("rst_busy", int'(bus.busy), 0);
    check("rst_path_len", int'(bus.path_len), 0);
    check("rst_path_planned", int'(bus.path_planned), 0);
    rst_n = 1'b1;
    tick();

    // Nominal route 0 -> 22
    write_parent(1, 0);  write_parent(29, 1); write_parent(20, 29);
    write_parent(21, 20); write_parent(22, 21);
    clear_mon(); start_path(0, 22); wait_idle();
    check_nominal("nominal");

    // Second start mid-EMIT must be ignored
    clear_mon(); start_path(0, 22);
    repeat (8) tick();
    start_path(5, 5);
    wait_idle();
    check_nominal("mid_emit_start");

    // Trivial one-node path
    clear_mon(); start_path(5, 5); wait_idle();
    check("trivial_count", mon_nodes.size(), 1);
    if (mon_nodes.size() > 0) check("trivial_node", mon_nodes[0], 5);
    check("trivial_done_ofs", done_at - start_t, 3);
    check("trivial_len", int'(bus.path_len), 1);

    // Table write while busy is dropped; a later trace proves the table
    clear_mon(); start_path(0, 22); tick(); write_parent(22, 3); wait_idle();
    clear_mon(); start_path(0, 22); wait_idle();
    check_nominal("busy_write");

    // Broken chain
    write_parent(21, 31);
    clear_mon(); start_path(0, 22); wait_idle();
    check("broken_err_ofs", err_at - start_t, 3);
    check("broken_no_nodes", mon_nodes.size(), 0);
    check("broken_len_kept", int'(bus.path_len), 6);

    // Cyclic table runs into the path-length limit
    write_parent(9, 8); write_parent(8, 9);
    clear_mon(); start_path(0, 9); wait_idle();
    check("cycle_err_ofs", err_at - start_t, 17);
    check("cycle_no_nodes", mon_nodes.size(), 0);

    // Out-of-range nodes and addresses
    clear_mon(); start_path(30, 0); wait_idle();
    check("range_start_err_ofs", err_at - start_t, 1);
    clear_mon(); start_path(0, 31); wait_idle();
    check("range_end_err_ofs", err_at - start_t, 1);
    write_parent(30, 0);

    // Reset after the third streamed node
    write_parent(21, 20);
    clear_mon(); start_path(0, 22);
    n = 0;
    while (mon_nodes.size() < 3 && n < 100) begin
      tick();
      n++;
    end
    check("reset_saw_three", mon_nodes.size(), 3);
    @(posedge clk_3125KHz);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_path_input", int'(bus.path_input), 0);
    check("reset_path_planned", int'(bus.path_planned), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done_err", int'(bus.done) + int'(bus.error), 0);
    check("reset_len", int'(bus.path_len), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    clear_mon(); start_path(0, 22); wait_idle();
    check("after_reset_err_ofs", err_at - start_t, 2);
    check("after_reset_no_nodes", mon_nodes.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
